lpc_stream_framer: RTL

// Upstream feeder for the DDR3 write-master stream port. Accepts a free-running 16-bit

---
 rtl/lpc_stream_framer_pkg.sv | 19 +
 rtl/lpc_stream_framer_if.sv | 13 +
 rtl/lpc_stream_framer_fifo.sv | 54 +++++
 rtl/lpc_stream_framer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/lpc_stream_framer_pkg.sv
// Shared types and helpers for the LPC stream framer: framer state encoding,
// default header tag and the occupancy-counter width rule.
package lpc_stream_framer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_HDR_TAG = 8'hA5;

    // Occupancy must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lpc_stream_framer_if.sv
// Sample-in / write-master-out stream bundle; master drives samples,
// slave (the framer) drives the write-master stream.
interface lpc_stream_framer_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic [DATA_W-1:0] wr_d_in;
    logic              wr_v;

    modport master (output src_data, output src_valid, input wr_d_in, input wr_v);
    modport slave  (input src_data, input src_valid, output wr_d_in, output wr_v);
endinterface

// File: rtl/lpc_stream_framer_fifo.sv
// Synchronous FIFO; rd_data presents the head word, which the framer captures
// into its output register on the pop cycle, giving one-cycle pop-to-output.
module lpc_stream_framer_fifo
    import lpc_stream_framer_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LVL_W  = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0]  level_r;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= ADDR_W'(0);
            rd_ptr_r <= ADDR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem_r[wr_ptr_r] <= wr_data;
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;
    assign full    = (level_r == LVL_W'(DEPTH));
    assign empty   = (level_r == LVL_W'(0));

endmodule

// File: rtl/lpc_stream_framer.sv
// Buffers a free-running sample stream and emits header-tagged fixed-length
// bursts to the DDR3 write-master stream port once calibration is done.
module lpc_stream_framer
    import lpc_stream_framer_pkg::*;
#(
    parameter  int         DATA_W     = 16,
    parameter  int         FIFO_DEPTH = 64,
    parameter  int         BURST_LEN  = 16,
    parameter  int         GAP_CYCLES = 2,
    parameter  logic [7:0] HDR_TAG    = DEFAULT_HDR_TAG,
    localparam int         LVL_W      = level_width(FIFO_DEPTH)
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                enable,
    input  logic                init_done,
    lpc_stream_framer_if.slave  bus,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [15:0]         overflow_cnt,
    output logic [15:0]         burst_cnt
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    state_t            state_r, state_nxt_s;
    logic [BEAT_W-1:0] beat_r;
    logic [GAP_W-1:0]  gap_r;
    logic [7:0]        seq_r;
    logic [15:0]       overflow_r, burst_r;
    logic [DATA_W-1:0] wr_d_in_r, head_s, hdr_word_s;
    logic              wr_v_r;
    logic              capture_s, push_s, drop_s, pop_s, full_s, empty_s, last_beat_s;

    assign capture_s   = bus.src_valid & enable & init_done;
    assign push_s      = capture_s & (~full_s | pop_s);
    assign drop_s      = capture_s & full_s & ~pop_s;
    assign last_beat_s = (state_r == BURST) && (beat_r == BEAT_W'(BURST_LEN - 1));
    assign hdr_word_s  = DATA_W'({HDR_TAG, seq_r});

    lpc_stream_framer_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (bus.src_data),
        .rd_data (head_s),
        .level   (fifo_level),
        .full    (full_s),
        .empty   (empty_s)
    );

    // State register.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state_r <= IDLE;
        else             state_r <= state_nxt_s;
    end

    // Next-state and pop decode; gating only blocks burst start, never truncates.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && init_done && (fifo_level >= LVL_W'(BURST_LEN))) state_nxt_s = HDR;
                else                                                          state_nxt_s = IDLE;
            end
            HDR:  state_nxt_s = BURST;
            BURST: begin
                pop_s = ~empty_s;
                if (last_beat_s) state_nxt_s = GAP;
                else             state_nxt_s = BURST;
            end
            GAP: begin
                if (gap_r == GAP_W'(GAP_CYCLES - 1)) state_nxt_s = IDLE;
                else                                 state_nxt_s = GAP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Beat and gap counters, cleared whenever their state is left.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            beat_r <= BEAT_W'(0);
            gap_r  <= GAP_W'(0);
        end else begin
            beat_r <= ((state_r == BURST) && !last_beat_s) ? beat_r + BEAT_W'(1) : BEAT_W'(0);
            gap_r  <= (state_r == GAP) ? gap_r + GAP_W'(1) : GAP_W'(0);
        end
    end

    // Output stream registers: header in HDR, popped head word in BURST.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_v_r    <= 1'b0;
            wr_d_in_r <= DATA_W'(0);
        end else begin
            wr_v_r <= (state_r == HDR) || (state_r == BURST);
            case (state_r)
                HDR:     wr_d_in_r <= hdr_word_s;
                BURST:   wr_d_in_r <= head_s;
                default: wr_d_in_r <= DATA_W'(0);
            endcase
        end
    end

    // Sequence tag, completed-burst and saturating drop counters.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            seq_r      <= 8'd0;
            burst_r    <= 16'd0;
            overflow_r <= 16'd0;
        end else begin
            if (last_beat_s) begin
                seq_r   <= seq_r + 8'd1;
                burst_r <= burst_r + 16'd1;
            end
            if (drop_s && (overflow_r != 16'hFFFF)) overflow_r <= overflow_r + 16'd1;
        end
    end

    assign bus.wr_v     = wr_v_r;
    assign bus.wr_d_in  = wr_d_in_r;
    assign overflow_cnt = overflow_r;
    assign burst_cnt    = burst_r;

endmodule
